// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the inst[31:7] field for one of the I/S/B/J/U formats.
// Two-stage elastic pipeline; also counts emitted items the format could not represent.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      imm_i,
  input  logic [2:0]       enc_func_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [24:0]      packed_o,
  output logic             out_err_o,
  input  logic             clr_count_i,
  output logic [CNT_W-1:0] err_count_o
);

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b100
  } fmt_e;

  logic             s1_valid_q;
  logic [31:0]      s1_imm_q;
  logic [2:0]       s1_func_q;
  logic             s2_valid_q;
  logic [24:0]      packed_q;
  logic             err_q;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] err_count_d;

  logic        s1_adv;
  logic        s2_adv;
  logic        in_fire;
  logic        out_fire;
  logic [24:0] packed_d;
  logic        err_d;
  logic        sext11_ok;
  logic        sext12_ok;
  logic        sext20_ok;

  assign s2_adv   = !s2_valid_q | out_ready_i;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_fire  = in_valid_i & s1_adv;
  assign out_fire = s2_valid_q & out_ready_i;

  // A value fits an N-bit signed field when every bit from N-1 upward matches the sign.
  assign sext11_ok = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
  assign sext12_ok = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
  assign sext20_ok = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);

  always_comb begin
    packed_d = '0;
    err_d    = 1'b1;
    case (s1_func_q)
      FMT_I: begin
        packed_d[24:13] = s1_imm_q[11:0];
        err_d           = !sext11_ok;
      end
      FMT_S: begin
        packed_d[24:18] = s1_imm_q[11:5];
        packed_d[4:0]   = s1_imm_q[4:0];
        err_d           = !sext11_ok;
      end
      FMT_B: begin
        packed_d[24]    = s1_imm_q[12];
        packed_d[23:18] = s1_imm_q[10:5];
        packed_d[4:1]   = s1_imm_q[4:1];
        packed_d[0]     = s1_imm_q[11];
        err_d           = s1_imm_q[0] | !sext12_ok;
      end
      FMT_J: begin
        packed_d[24]    = s1_imm_q[20];
        packed_d[23:14] = s1_imm_q[10:1];
        packed_d[13]    = s1_imm_q[11];
        packed_d[12:5]  = s1_imm_q[19:12];
        err_d           = s1_imm_q[0] | !sext20_ok;
      end
      FMT_U: begin
        packed_d[24:5] = s1_imm_q[31:12];
        err_d          = |s1_imm_q[11:0];
      end
      default: begin
        packed_d = '0;
        err_d    = 1'b1;
      end
    endcase
  end

  // Clear has priority so a clear issued alongside an error transfer still leaves zero.
  always_comb begin
    err_count_d = err_count_q;
    if (clr_count_i) begin
      err_count_d = '0;
    end else if (out_fire && err_q && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_imm_q    <= '0;
      s1_func_q   <= '0;
      s2_valid_q  <= 1'b0;
      packed_q    <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid_i;
      end
      if (in_fire) begin
        s1_imm_q  <= imm_i;
        s1_func_q <= enc_func_i;
      end
      // Stage 2 data only changes when a new item moves in, so it holds under backpressure.
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          packed_q <= packed_d;
          err_q    <= err_d;
        end
      end
      err_count_q <= err_count_d;
    end
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid_q;
  assign packed_o    = packed_q;
  assign out_err_o   = err_q;
  assign err_count_o = err_count_q;

endmodule
